// File: rtl/list_fold_sum.sv
// list_fold_sum: consumes a req/ack/eol/value list stream and folds every
// element into a signed, wrapping running sum and an element count. It is
// started and held with ready; done marks a final result.
//
// Optional feature macro: LIST_FOLD_EMPTY_LIST_EN
//   When defined, list_eol is sampled in START so that an empty list finishes
//   without issuing any request. When undefined, the producer must supply at
//   least one element.
module list_fold_sum #(
  parameter int VALUE_WIDTH = 8,
  parameter int ACC_WIDTH   = 16,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ready,
  output logic                   done,
  output logic [ACC_WIDTH-1:0]   result,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   list_req,
  input  logic                   list_ack,
  input  logic                   list_eol,
  input  logic [VALUE_WIDTH-1:0] list_value
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    REQ   = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   result_q, result_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   done_q, done_d;
  logic                   req_q, req_d;
  logic [ACC_WIDTH-1:0]   value_ext;

  // Sign-extend the element to accumulator width; the add then wraps naturally.
  assign value_ext = ACC_WIDTH'($signed(list_value));

  // Next-state and next-output decode; ready low overrides every state.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    count_d  = count_q;
    if (!ready) begin
      state_d  = IDLE;
      result_d = '0;
      count_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          result_d = '0;
          count_d  = '0;
          state_d  = START;
        end
        START: begin
`ifdef LIST_FOLD_EMPTY_LIST_EN
          // Producer outputs have settled: an eol here means an empty list.
          state_d = list_eol ? DONE : REQ;
`else
          state_d = REQ;
`endif
        end
        REQ:  state_d = WAIT;
        WAIT: begin
          if (list_ack) begin
            result_d = result_q + value_ext;
            count_d  = count_q + 1'b1;
            state_d  = list_eol ? DONE : REQ;
          end
        end
        DONE:    state_d = DONE;
        default: begin
          state_d  = IDLE;
          result_d = '0;
          count_d  = '0;
        end
      endcase
    end
    // Outputs are registered from the next state so they are glitch-free
    // and line up with the state register.
    done_d = (state_d == DONE);
    req_d  = (state_d == REQ);
  end

  // State and registered outputs; synchronous reset wins over everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      count_q  <= count_d;
      done_q   <= done_d;
      req_q    <= req_d;
    end
  end

  assign done     = done_q;
  assign result   = result_q;
  assign count    = count_q;
  assign list_req = req_q;

endmodule

// File: tb/tb_list_fold_sum.sv
// Directed bench for list_fold_sum with a stub list producer. A second
// instance with an 8-bit accumulator runs in lockstep to cover wrapping.
module tb_list_fold_sum;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ready = 1'b0;
  logic        done, done8;
  logic [15:0] result;
  logic [7:0]  result8;
  logic [7:0]  count, count8;
  logic        req, req8;
  logic        ack = 1'b0;
  logic        eol = 1'b0;
  logic [7:0]  value = 8'd0;

  int total = 0;
  int bad   = 0;

  // stub producer configuration
  logic        prod_clr = 1'b0;
  logic        eol_force = 1'b0;
  logic [7:0]  plist [8];
  int          plen = 1;
  int          pdelay = 0;
  int          idx = 0;
  int          wcnt = 0;
  logic        req_prev = 1'b0;
  logic        fire;

  // request pulse monitor
  logic        mon_prev = 1'b0;
  int          pulses = 0;
  int          wide = 0;

  always #5 clk = ~clk;

  list_fold_sum #(.VALUE_WIDTH(8), .ACC_WIDTH(16), .COUNT_WIDTH(8)) dut (
    .clock(clk), .reset(reset), .ready(ready), .done(done), .result(result),
    .count(count), .list_req(req), .list_ack(ack), .list_eol(eol),
    .list_value(value)
  );

  list_fold_sum #(.VALUE_WIDTH(8), .ACC_WIDTH(8), .COUNT_WIDTH(8)) dut8 (
    .clock(clk), .reset(reset), .ready(ready), .done(done8), .result(result8),
    .count(count8), .list_req(req8), .list_ack(ack), .list_eol(eol),
    .list_value(value)
  );

  // Producer answers a rising request edge after pdelay extra cycles.
  assign fire = !prod_clr && ((req && !req_prev && pdelay == 0) || wcnt == 1);

  always @(posedge clk) begin
    if (prod_clr) begin
      idx <= 0; ack <= 1'b0; eol <= 1'b0; wcnt <= 0; req_prev <= 1'b0;
    end else begin
      req_prev <= req;
      ack      <= fire;
      if (eol_force) eol <= 1'b1;
      if (req && !req_prev && pdelay != 0) wcnt <= pdelay;
      else if (wcnt != 0) wcnt <= wcnt - 1;
      if (fire) begin
        value <= plist[idx];
        if (idx == plen - 1) eol <= 1'b1;
        idx <= idx + 1;
      end
    end
  end

  always @(posedge clk) begin
    mon_prev <= req;
    if (req && !mon_prev) pulses <= pulses + 1;
    if (req && mon_prev)  wide   <= wide + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // advance n rising edges and settle just after the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic prod_reset();
    prod_clr = 1'b1;
    tick(1);
    prod_clr = 1'b0;
  endtask

  task automatic load4(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d, input int n);
    plist[0] = a; plist[1] = b; plist[2] = c; plist[3] = d;
    plen = n;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_done"},   32'(done),   32'd0);
    chk({tag, "_result"}, 32'(result), 32'd0);
    chk({tag, "_count"},  32'(count),  32'd0);
    chk({tag, "_req"},    32'(req),    32'd0);
  endtask

  int p0;

  initial begin
    for (int i = 0; i < 8; i++) plist[i] = 8'd0;
    prod_clr = 1'b1;
    tick(2);
    chk_zero("reset");
    reset = 1'b0;
    prod_clr = 1'b0;
    tick(1);
    chk_zero("idle");

    // 1, 3, 5, 7 -> 16 after edge 9, four clean request pulses
    load4(8'd1, 8'd3, 8'd5, 8'd7, 4);
    pdelay = 0;
    p0 = pulses;
    ready = 1'b1;
    tick(9);
    chk("l4_done_e8", 32'(done), 32'd0);
    tick(1);
    chk("l4_done_e9", 32'(done), 32'd1);
    chk("l4_result", 32'(result), 32'd16);
    chk("l4_count", 32'(count), 32'd4);
    chk("l4_pulses", 32'(pulses - p0), 32'd4);
    chk("l4_wide", 32'(wide), 32'd0);
    tick(2);
    chk("l4_hold_done", 32'(done), 32'd1);
    chk("l4_hold_result", 32'(result), 32'd16);
    ready = 1'b0;
    tick(1);
    chk_zero("l4_drop");
    prod_reset();

    // -5, 0, 5 -> 0 (sign extension), done after edge 7
    load4(8'hFB, 8'd0, 8'd5, 8'd0, 3);
    ready = 1'b1;
    tick(7);
    chk("neg_done_e6", 32'(done), 32'd0);
    tick(1);
    chk("neg_done_e7", 32'(done), 32'd1);
    chk("neg_result", 32'(result), 32'd0);
    chk("neg_count", 32'(count), 32'd3);
    ready = 1'b0;
    tick(1);
    prod_reset();

    // 100, 110, 120 -> 330 (16-bit), 74 = 0x4A (8-bit wrap)
    load4(8'd100, 8'd110, 8'd120, 8'd0, 3);
    ready = 1'b1;
    tick(8);
    chk("wrap_done", 32'(done), 32'd1);
    chk("wrap_result16", 32'(result), 32'd330);
    chk("wrap_done8", 32'(done8), 32'd1);
    chk("wrap_result8", 32'(result8), 32'h4A);
    chk("wrap_count8", 32'(count8), 32'd3);
    ready = 1'b0;
    tick(1);
    prod_reset();

    // abort in WAIT after two elements, then full restart
    load4(8'd1, 8'd3, 8'd5, 8'd7, 4);
    ready = 1'b1;
    tick(7);
    chk("abort_pre_count", 32'(count), 32'd2);
    chk("abort_pre_result", 32'(result), 32'd4);
    ready = 1'b0;
    tick(1);
    chk_zero("abort");
    prod_reset();
    ready = 1'b1;
    tick(10);
    chk("restart_done", 32'(done), 32'd1);
    chk("restart_result", 32'(result), 32'd16);
    chk("restart_count", 32'(count), 32'd4);
    ready = 1'b0;
    tick(1);
    prod_reset();

    // slow producer: ack five cycles late, then reset mid-WAIT
    load4(8'd10, 8'd20, 8'd0, 8'd0, 2);
    pdelay = 5;
    ready = 1'b1;
    tick(5);
    chk("slow_wait_req", 32'(req), 32'd0);
    chk("slow_wait_count", 32'(count), 32'd0);
    tick(4);
    chk("slow_count", 32'(count), 32'd1);
    chk("slow_result", 32'(result), 32'd10);
    tick(3);
    chk("slow_nodup", 32'(count), 32'd1);
    reset = 1'b1;
    tick(1);
    chk_zero("slow_reset");
    ready = 1'b0;
    reset = 1'b0;
    pdelay = 0;
    tick(1);
    prod_reset();

    // eol held high from the start
    load4(8'd9, 8'd0, 8'd0, 8'd0, 1);
    eol_force = 1'b1;
    p0 = pulses;
    ready = 1'b1;
    tick(1);
    chk("empty_e0_req", 32'(req), 32'd0);
    tick(1);
`ifdef LIST_FOLD_EMPTY_LIST_EN
    chk("empty_done", 32'(done), 32'd1);
    chk("empty_result", 32'(result), 32'd0);
    chk("empty_count", 32'(count), 32'd0);
    tick(3);
    chk("empty_no_req", 32'(pulses - p0), 32'd0);
`else
    chk("empty_req", 32'(req), 32'd1);
    chk("empty_done", 32'(done), 32'd0);
`endif
    ready = 1'b0;
    eol_force = 1'b0;
    tick(1);
    chk_zero("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
